accumulator_row_sequencer: RTL

- Sequences a row-major matrix element stream into the AXI-stream floating-point accumulator.
- Marks the last element of every M_SIZE-element row with tlast and keeps only the final sum of each row. Intermediate running sums are discarded.
- Tags each row sum with its row index and limits how many rows are in flight inside the accumulator pipeline.
- Sits between the element buffer and the row-sum collector of the matrix-vector multiplier.

---
 rtl/accumulator_row_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/accumulator_row_sequencer.sv
// Feeds a row-major element stream into the floating-point accumulator, marks the
// end of each row with tlast, keeps only final row sums and limits rows in flight.
//
// state   | meaning
// S_IDLE  | waiting for i_start; row count latched on start
// S_RUN   | passing elements through to the accumulator
// S_DRAIN | every row issued; waiting for the remaining row sums to leave
// S_DONE  | one-cycle completion pulse
module accumulator_row_sequencer #(
    parameter int D_WIDTH = 32,
    parameter int M_SIZE  = 4,
    parameter int ROW_W   = 16,
    parameter int MAX_OUT = 4
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               i_start,
    input  logic [ROW_W-1:0]   i_num_rows,
    output logic               o_busy,
    output logic               o_done,
    input  logic               i_elem_tvalid,
    output logic               o_elem_tready,
    input  logic [D_WIDTH-1:0] i_elem_tdata,
    output logic               o_acc_tvalid,
    input  logic               i_acc_tready,
    output logic [D_WIDTH-1:0] o_acc_tdata,
    output logic               o_acc_tlast,
    input  logic               i_res_tvalid,
    output logic               o_res_tready,
    input  logic [D_WIDTH-1:0] i_res_tdata,
    input  logic               i_res_tlast,
    output logic               o_sum_tvalid,
    input  logic               i_sum_tready,
    output logic [D_WIDTH-1:0] o_sum_tdata,
    output logic [ROW_W-1:0]   o_sum_row_idx,
    output logic               o_sum_tlast
);

    localparam int CW = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] COL_LAST = CW'(M_SIZE - 1);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   num_rows_q, num_rows_d;
    logic [CW-1:0]      col_q, col_d;
    logic [ROW_W-1:0]   rows_issued_q, rows_issued_d;
    logic [ROW_W-1:0]   rows_done_q, rows_done_d;
    logic [OW-1:0]      outstanding_q, outstanding_d;
    logic               sum_valid_q, sum_valid_d;
    logic [D_WIDTH-1:0] sum_data_q, sum_data_d;
    logic [ROW_W-1:0]   sum_idx_q, sum_idx_d;
    logic               sum_last_q, sum_last_d;

    logic               gate;
    logic               acc_hs;
    logic               row_end_hs;
    logic               res_hs;
    logic               res_final;
    logic               sum_drain;
    logic [ROW_W-1:0]   last_row;

    // Credit is only checked at a row boundary; a row already started runs to its end.
    always_comb begin
        gate          = (state_q == S_RUN) && !((col_q == '0) && (outstanding_q == OUT_MAX));
        o_acc_tvalid  = i_elem_tvalid & gate;
        o_elem_tready = i_acc_tready & gate;
        o_acc_tdata   = i_elem_tdata;
        o_acc_tlast   = (col_q == COL_LAST);
        acc_hs        = o_acc_tvalid & i_acc_tready;
        row_end_hs    = acc_hs & o_acc_tlast;
        o_res_tready  = !i_res_tlast | !sum_valid_q | i_sum_tready;
        res_hs        = i_res_tvalid & o_res_tready;
        res_final     = res_hs & i_res_tlast & (outstanding_q != '0);
        sum_drain     = sum_valid_q & i_sum_tready;
        last_row      = num_rows_q - ROW_W'(1);
    end

    always_comb begin
        state_d       = state_q;
        num_rows_d    = num_rows_q;
        col_d         = col_q;
        rows_issued_d = rows_issued_q;
        rows_done_d   = rows_done_q;
        outstanding_d = outstanding_q;
        sum_valid_d   = sum_valid_q;
        sum_data_d    = sum_data_q;
        sum_idx_d     = sum_idx_q;
        sum_last_d    = sum_last_q;

        if (acc_hs) begin
            col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
        end
        if (row_end_hs) begin
            rows_issued_d = rows_issued_q + ROW_W'(1);
        end

        case ({row_end_hs, res_final})
            2'b10: begin
                if (outstanding_q != OUT_MAX) begin
                    outstanding_d = outstanding_q + OW'(1);
                end
            end
            2'b01: outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase

        // A new final sum overwrites the register in the same cycle it drains.
        if (res_final) begin
            sum_valid_d = 1'b1;
            sum_data_d  = i_res_tdata;
            sum_idx_d   = rows_done_q;
            sum_last_d  = (rows_done_q == last_row);
            rows_done_d = rows_done_q + ROW_W'(1);
        end else if (sum_drain) begin
            sum_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    num_rows_d    = i_num_rows;
                    col_d         = '0;
                    rows_issued_d = '0;
                    rows_done_d   = '0;
                    state_d       = (i_num_rows == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (row_end_hs && (rows_issued_q == last_row)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((outstanding_q == '0) && !sum_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q       <= S_IDLE;
            num_rows_q    <= '0;
            col_q         <= '0;
            rows_issued_q <= '0;
            rows_done_q   <= '0;
            outstanding_q <= '0;
            sum_valid_q   <= 1'b0;
            sum_data_q    <= '0;
            sum_idx_q     <= '0;
            sum_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_rows_q    <= num_rows_d;
            col_q         <= col_d;
            rows_issued_q <= rows_issued_d;
            rows_done_q   <= rows_done_d;
            outstanding_q <= outstanding_d;
            sum_valid_q   <= sum_valid_d;
            sum_data_q    <= sum_data_d;
            sum_idx_q     <= sum_idx_d;
            sum_last_q    <= sum_last_d;
        end
    end

    assign o_busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done        = (state_q == S_DONE);
    assign o_sum_tvalid  = sum_valid_q;
    assign o_sum_tdata   = sum_data_q;
    assign o_sum_row_idx = sum_idx_q;
    assign o_sum_tlast   = sum_last_q;

endmodule
